// File: rtl/ifmux_drr_sched_if.sv
// Request/grant bundle between the per-port rx pointer fifos, the DRR scheduler and the store mux.
// No logic: the master side drives requests/acks, the slave side (scheduler) drives the grant.
// Backpressure (bp) and grant_ack travel on this bundle alongside the requests.
interface ifmux_drr_sched_if;
    logic [3:0]  req;
    logic [10:0] req_len0;
    logic [10:0] req_len1;
    logic [10:0] req_len2;
    logic [10:0] req_len3;
    logic [3:0]  req_err;
    logic        bp;
    logic        grant_ack;
    logic        xfer_done;
    logic        grant_valid;
    logic [3:0]  grant_vec;
    logic [1:0]  grant_bin;
    logic [10:0] grant_len;
    logic        busy;

    modport master (
        output req, req_len0, req_len1, req_len2, req_len3, req_err,
        output bp, grant_ack, xfer_done,
        input  grant_valid, grant_vec, grant_bin, grant_len, busy
    );

    modport slave (
        input  req, req_len0, req_len1, req_len2, req_len3, req_err,
        input  bp, grant_ack, xfer_done,
        output grant_valid, grant_vec, grant_bin, grant_len, busy
    );
endinterface

// File: rtl/ifmux_drr_sched.sv
// Deficit-round-robin grant scheduler for 4 ingress ports; optional IFMUX_SCHED_STRICT_P0_EN gives port 0 strict priority.
// Latency: 2 cycles IDLE->grant_valid when the pointed port already holds enough deficit, one port visited per SCAN cycle.
// Backpressure: bp blocks new grants only (IDLE/SCAN); a committed grant runs through ack and xfer_done regardless.
module ifmux_drr_sched #(
    parameter int QUANTUM = 1536,
    parameter int DEF_W   = 13
) (
    input  logic             clk_sys,
    input  logic             rstn_sys,
    ifmux_drr_sched_if.slave sif
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SCAN  = 4'b0010,
        ST_GRANT = 4'b0100,
        ST_XFER  = 4'b1000
    } state_e;

    localparam logic [DEF_W:0] QUANT_X = (DEF_W+1)'(QUANTUM);
    localparam logic [DEF_W:0] DEF_MAX = {1'b0, {DEF_W{1'b1}}};

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [DEF_W-1:0]   deficit_q [4];
    logic [DEF_W-1:0]   deficit_d [4];
    logic [3:0]         gnt_vec_q, gnt_vec_d;
    logic [1:0]         gnt_bin_q, gnt_bin_d;
    logic [10:0]        gnt_len_q, gnt_len_d;
    logic               nochg_q, nochg_d;

    logic [10:0]        req_len [4];
    logic [1:0]         ptr_nxt;
    logic [DEF_W-1:0]   cur_def;
    logic               def_ok;
    logic [DEF_W:0]     credit_sum;
    logic [DEF_W-1:0]   credit_sat;
    logic [DEF_W-1:0]   g_def;
    logic [DEF_W-1:0]   g_len_x;
    logic [DEF_W-1:0]   charged;

    assign req_len[0] = sif.req_len0;
    assign req_len[1] = sif.req_len1;
    assign req_len[2] = sif.req_len2;
    assign req_len[3] = sif.req_len3;

    assign ptr_nxt    = ptr_q + 2'd1;
    assign cur_def    = deficit_q[ptr_q];
    assign def_ok     = cur_def >= DEF_W'(req_len[ptr_q]);

    // Quantum credit for the port being advanced to, clamped at the counter ceiling.
    assign credit_sum = {1'b0, deficit_q[ptr_nxt]} + QUANT_X;
    assign credit_sat = (credit_sum > DEF_MAX) ? DEF_MAX[DEF_W-1:0] : credit_sum[DEF_W-1:0];

    assign g_def      = deficit_q[gnt_bin_q];
    assign g_len_x    = DEF_W'(gnt_len_q);
    assign charged    = (g_def >= g_len_x) ? (g_def - g_len_x) : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        deficit_d = deficit_q;
        gnt_vec_d = gnt_vec_q;
        gnt_bin_d = gnt_bin_q;
        gnt_len_d = gnt_len_q;
        nochg_d   = nochg_q;

        case (state_q)
            ST_IDLE: begin
                if ((sif.req != 4'b0000) && !sif.bp) begin
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (sif.bp || (sif.req == 4'b0000)) begin
                    state_d = ST_IDLE;
                end
`ifdef IFMUX_SCHED_STRICT_P0_EN
                else if (sif.req[0]) begin
                    // Priority grant leaves ptr and all deficits untouched so DRR resumes where it was.
                    state_d   = ST_GRANT;
                    gnt_vec_d = 4'b0001;
                    gnt_bin_d = 2'd0;
                    gnt_len_d = req_len[0];
                    nochg_d   = 1'b1;
                end
`endif
                else if (!sif.req[ptr_q]) begin
                    deficit_d[ptr_q]   = '0;
                    ptr_d              = ptr_nxt;
                    deficit_d[ptr_nxt] = credit_sat;
                end else if (sif.req_err[ptr_q] || def_ok) begin
                    // Errored frames are flushed without costing the port any deficit.
                    state_d   = ST_GRANT;
                    gnt_vec_d = 4'b0001 << ptr_q;
                    gnt_bin_d = ptr_q;
                    gnt_len_d = req_len[ptr_q];
                    nochg_d   = sif.req_err[ptr_q];
                end else begin
                    ptr_d              = ptr_nxt;
                    deficit_d[ptr_nxt] = credit_sat;
                end
            end

            ST_GRANT: begin
                if (sif.grant_ack) begin
                    state_d = ST_XFER;
                    if (!nochg_q) begin
                        deficit_d[gnt_bin_q] = charged;
                    end
                end
            end

            ST_XFER: begin
                if (sif.xfer_done) begin
                    state_d = ST_SCAN;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            gnt_vec_q <= 4'b0000;
            gnt_bin_q <= 2'd0;
            gnt_len_q <= 11'd0;
            nochg_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                deficit_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_vec_q <= gnt_vec_d;
            gnt_bin_q <= gnt_bin_d;
            gnt_len_q <= gnt_len_d;
            nochg_q   <= nochg_d;
            for (int i = 0; i < 4; i++) begin
                deficit_q[i] <= deficit_d[i];
            end
        end
    end

    assign sif.grant_valid = (state_q == ST_GRANT);
    assign sif.busy        = (state_q == ST_GRANT) || (state_q == ST_XFER);
    assign sif.grant_vec   = gnt_vec_q;
    assign sif.grant_bin   = gnt_bin_q;
    assign sif.grant_len   = gnt_len_q;

    a_state_onehot: assert property (@(posedge clk_sys) disable iff (!rstn_sys)
        $onehot(state_q));

    a_grant_onehot: assert property (@(posedge clk_sys) disable iff (!rstn_sys)
        sif.grant_valid |-> $onehot(sif.grant_vec));

    a_grant_stable: assert property (@(posedge clk_sys) disable iff (!rstn_sys)
        (sif.grant_valid && !sif.grant_ack) |=> (sif.grant_valid && $stable(sif.grant_vec)
                                                 && $stable(sif.grant_len)));

endmodule

// File: tb/tb_ifmux_drr_sched.sv
// Directed bench for the DRR scheduler: reset, first-grant latency, error grants, backpressure,
// async reset mid-transfer and the 1500B/64B fairness mix, all with hand-computed expectations.
module tb_ifmux_drr_sched;
    localparam int QUANTUM = 1536;

    logic clk_sys = 1'b0;
    logic rstn_sys;
    int   n_chk  = 0;
    int   n_fail = 0;

    ifmux_drr_sched_if sif();

    ifmux_drr_sched #(.QUANTUM(QUANTUM), .DEF_W(13)) dut (
        .clk_sys  (clk_sys),
        .rstn_sys (rstn_sys),
        .sif      (sif)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic apply_reset();
        sif.req       = 4'b0000;
        sif.req_err   = 4'b0000;
        sif.req_len0  = 11'd0;
        sif.req_len1  = 11'd0;
        sif.req_len2  = 11'd0;
        sif.req_len3  = 11'd0;
        sif.bp        = 1'b0;
        sif.grant_ack = 1'b0;
        sif.xfer_done = 1'b0;
        rstn_sys      = 1'b0;
        repeat (2) @(negedge clk_sys);
        rstn_sys = 1'b1;
        @(negedge clk_sys);
    endtask

    // Counts negedges from the call until grant_valid is seen, bounded.
    task automatic wait_grant(input string tag, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk_sys);
            n++;
            if (sif.grant_valid) break;
        end
        check_val(tag, sif.grant_valid, 1);
    endtask

    task automatic pulse_ack();
        sif.grant_ack = 1'b1;
        @(negedge clk_sys);
        sif.grant_ack = 1'b0;
    endtask

    task automatic pulse_done();
        sif.xfer_done = 1'b1;
        @(negedge clk_sys);
        sif.xfer_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int g0, g1, bytes0, bytes1, bad_len, diff;

        // Reset values and ack ignored in IDLE
        apply_reset();
        check_val("rst_valid", sif.grant_valid, 0);
        check_val("rst_vec",   sif.grant_vec,   0);
        check_val("rst_bin",   sif.grant_bin,   0);
        check_val("rst_len",   sif.grant_len,   0);
        check_val("rst_busy",  sif.busy,        0);
        check_val("rst_state", dut.state_q,     4'b0001);
        check_val("rst_ptr",   dut.ptr_q,       0);
        for (int i = 0; i < 4; i++) check_val("rst_def", dut.deficit_q[i], 0);
        pulse_ack();
        check_val("idle_ack_state", dut.state_q, 4'b0001);

        // Single port 0 frame of 64B: visits 0,1,2,3,0 then grants
        sif.req = 4'b0001;
        sif.req_len0 = 11'd64;
        wait_grant("p0_grant", n);
        check_val("p0_latency", n, 6);
        check_val("p0_vec", sif.grant_vec, 4'b0001);
        check_val("p0_bin", sif.grant_bin, 0);
        check_val("p0_len", sif.grant_len, 64);
        check_val("p0_busy", sif.busy, 1);
        check_val("p0_def0_pre", dut.deficit_q[0], QUANTUM);
        check_val("p0_def1_pre", dut.deficit_q[1], 0);
        check_val("p0_def3_pre", dut.deficit_q[3], 0);
        pulse_done();
        check_val("grant_done_ignored", sif.grant_valid, 1);
        sif.req = 4'b0000;
        sif.req_len0 = 11'd100;
        @(negedge clk_sys);
        check_val("grant_len_held", sif.grant_len, 64);
        pulse_ack();
        check_val("xfer_valid", sif.grant_valid, 0);
        check_val("xfer_busy", sif.busy, 1);
        check_val("p0_def0_post", dut.deficit_q[0], 1472);
        pulse_ack();
        check_val("xfer_ack_ignored", sif.busy, 1);
        check_val("xfer_ack_nochg", dut.deficit_q[0], 1472);
        pulse_done();
        check_val("done_busy", sif.busy, 0);
        @(negedge clk_sys);
        check_val("scan_to_idle", dut.state_q, 4'b0001);
        check_val("idle_def0", dut.deficit_q[0], 1472);

        // Error frame on port 1 longer than its deficit: granted on first visit, not charged
        apply_reset();
        sif.req = 4'b0010;
        sif.req_err = 4'b0010;
        sif.req_len1 = 11'd2047;
        wait_grant("err_grant", n);
        check_val("err_latency", n, 3);
        check_val("err_vec", sif.grant_vec, 4'b0010);
        check_val("err_bin", sif.grant_bin, 1);
        check_val("err_len", sif.grant_len, 2047);
        check_val("err_def1_pre", dut.deficit_q[1], QUANTUM);
        sif.grant_ack = 1'b1;
        sif.xfer_done = 1'b1;
        @(negedge clk_sys);
        sif.grant_ack = 1'b0;
        sif.xfer_done = 1'b0;
        check_val("ackdone_busy", sif.busy, 1);
        check_val("ackdone_valid", sif.grant_valid, 0);
        check_val("err_def1_post", dut.deficit_q[1], QUANTUM);
        sif.req = 4'b0000;
        sif.req_err = 4'b0000;
        pulse_done();
        check_val("err_done_busy", sif.busy, 0);

        // Backpressure during GRANT: grant completes, then park in IDLE
        apply_reset();
        sif.req = 4'b0001;
        sif.req_len0 = 11'd64;
        wait_grant("bp_grant", n);
        sif.bp = 1'b1;
        repeat (3) @(negedge clk_sys);
        check_val("bp_hold_valid", sif.grant_valid, 1);
        check_val("bp_hold_len", sif.grant_len, 64);
        pulse_ack();
        check_val("bp_xfer_busy", sif.busy, 1);
        pulse_done();
        repeat (4) @(negedge clk_sys);
        check_val("bp_park_state", dut.state_q, 4'b0001);
        check_val("bp_park_valid", sif.grant_valid, 0);
        check_val("bp_park_def0", dut.deficit_q[0], 1472);
        sif.bp = 1'b0;
        wait_grant("bp_release_grant", n);
        check_val("min_latency", n, 2);
        pulse_ack();
        check_val("bp_def0_2nd", dut.deficit_q[0], 1408);

        // Asynchronous reset while in XFER
        @(posedge clk_sys);
        #2;
        rstn_sys = 1'b0;
        sif.req  = 4'b0000;
        #1;
        check_val("arst_valid", sif.grant_valid, 0);
        check_val("arst_busy",  sif.busy, 0);
        check_val("arst_vec",   sif.grant_vec, 0);
        check_val("arst_len",   sif.grant_len, 0);
        check_val("arst_state", dut.state_q, 4'b0001);
        for (int i = 0; i < 4; i++) check_val("arst_def", dut.deficit_q[i], 0);
        @(negedge clk_sys);
        rstn_sys = 1'b1;
        repeat (10) @(negedge clk_sys);
        check_val("arst_no_grant", sif.grant_valid, 0);
        check_val("arst_idle", dut.state_q, 4'b0001);
        sif.req = 4'b0001;
        wait_grant("arst_regrant", n);
        check_val("arst_regrant_lat", n, 6);
        pulse_ack();
        sif.req = 4'b0000;
        pulse_done();

        // Fairness: port 0 1500B frames vs port 1 64B frames over 100 grants
        apply_reset();
        sif.req = 4'b0011;
        sif.req_len0 = 11'd1500;
        sif.req_len1 = 11'd64;
        g0 = 0; g1 = 0; bytes0 = 0; bytes1 = 0; bad_len = 0;
        for (int k = 0; k < 100; k++) begin
            wait_grant("fair_grant", n);
            if (sif.grant_bin == 2'd0) begin
                g0++;
                bytes0 += int'(sif.grant_len);
                if (sif.grant_len != 11'd1500) bad_len++;
            end else begin
                g1++;
                bytes1 += int'(sif.grant_len);
                if (sif.grant_len != 11'd64) bad_len++;
            end
            pulse_ack();
            pulse_done();
        end
        sif.req = 4'b0000;
        diff = (bytes0 > bytes1) ? (bytes0 - bytes1) : (bytes1 - bytes0);
        check_val("fair_g0", g0, 4);
        check_val("fair_g1", g1, 96);
        check_val("fair_bytes0", bytes0, 6000);
        check_val("fair_bytes1", bytes1, 6144);
        check_val("fair_within_quantum", diff <= QUANTUM, 1);
        check_val("fair_len", bad_len, 0);
        check_val("fair_def0", dut.deficit_q[0], 144);
        check_val("fair_def1", dut.deficit_q[1], 0);

`ifdef IFMUX_SCHED_STRICT_P0_EN
        // Strict port 0: granted whenever pending, DRR resumes from saved ptr afterwards
        apply_reset();
        sif.req = 4'b1111;
        sif.req_len0 = 11'd64;
        sif.req_len1 = 11'd64;
        sif.req_len2 = 11'd64;
        sif.req_len3 = 11'd64;
        wait_grant("sp_grant1", n);
        check_val("sp_lat1", n, 2);
        check_val("sp_bin1", sif.grant_bin, 0);
        pulse_ack();
        check_val("sp_def0", dut.deficit_q[0], 0);
        pulse_done();
        wait_grant("sp_grant2", n);
        check_val("sp_lat2", n, 1);
        check_val("sp_bin2", sif.grant_bin, 0);
        pulse_ack();
        sif.req = 4'b1110;
        pulse_done();
        wait_grant("sp_grant3", n);
        check_val("sp_lat3", n, 2);
        check_val("sp_bin3", sif.grant_bin, 1);
        pulse_ack();
        check_val("sp_def1", dut.deficit_q[1], 1472);
        sif.req = 4'b0000;
        pulse_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
